// File: rtl/sdram_traffic_checker.sv
// Self-checking SDRAM traffic generator: writes/reads NUM_WORDS seeded patterns
// through the controller user ports and counts readback mismatches and timeouts.
`timescale 1ns/1ps
module sdram_traffic_checker #(
  parameter int unsigned       ADDR_W      = 22,
  parameter int unsigned       DATA_W      = 128,
  parameter int unsigned       NUM_WORDS   = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       ADDR_STRIDE = 1,
  parameter int unsigned       ACK_TIMEOUT = 1024,
  parameter logic [31:0]       SEED        = 32'hACE12345
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              istart,
  input  logic [1:0]        imode,
  input  logic              iinit_done,
  output logic              owrite_req,
  output logic [ADDR_W-1:0] owrite_address,
  output logic [DATA_W-1:0] owrite_data,
  input  logic              iwrite_ack,
  output logic              oread_req,
  output logic [ADDR_W-1:0] oread_address,
  input  logic [DATA_W-1:0] iread_data,
  input  logic              iread_ack,
  output logic              obusy,
  output logic              odone,
  output logic              opass,
  output logic [15:0]       oerr_count,
  output logic [ADDR_W-1:0] ofirst_err_addr,
  output logic              otimeout
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned NS = DATA_W / 32;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WR_ISSUE, S_WR_WAIT,
    S_RD_ISSUE, S_RD_WAIT, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [15:0]       idx, idx_n;
  logic [1:0]        mode;
  logic [TW-1:0]     tcnt;
  logic [ADDR_W-1:0] waddr, raddr, first_addr;
  logic [DATA_W-1:0] wdata;
  logic [15:0]       errs;
  logic              tmo, tmo_hit;
  logic              last, start, mism, expired;

  function automatic logic [DATA_W-1:0] pattern(input logic [15:0] i);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int k = 0; k < NS; k++)
      p[k*32 +: 32] = SEED ^ {i, 8'(k), 8'h5A};
    return p;
  endfunction

  function automatic logic [ADDR_W-1:0] address(input logic [15:0] i);
    return BASE_ADDR + ADDR_W'(i) * ADDR_W'(ADDR_STRIDE);
  endfunction

  assign last    = (idx == 16'(NUM_WORDS - 1));
  assign start   = istart && (state == S_IDLE || state == S_DONE);
  assign mism    = (iread_data != pattern(idx));
  assign expired = (tcnt == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    state_n = state;
    idx_n   = idx;
    tmo_hit = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (istart) state_n = S_INIT;
      S_INIT: if (iinit_done) begin
        idx_n   = '0;
        state_n = (mode == 2'd2) ? S_RD_ISSUE : S_WR_ISSUE;
      end
      S_WR_ISSUE: state_n = S_WR_WAIT;
      S_WR_WAIT: if (iwrite_ack) begin
        if (mode == 2'd1) begin
          state_n = S_RD_ISSUE;
        end else if (last) begin
          idx_n   = '0;
          state_n = S_RD_ISSUE;
        end else begin
          idx_n   = idx + 16'd1;
          state_n = S_WR_ISSUE;
        end
      end else if (expired) begin
        tmo_hit = 1'b1;
        state_n = S_DONE;
      end
      S_RD_ISSUE: state_n = S_RD_WAIT;
      S_RD_WAIT: if (iread_ack) begin
        if (last) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + 16'd1;
          state_n = (mode == 2'd1) ? S_WR_ISSUE : S_RD_ISSUE;
        end
      end else if (expired) begin
        tmo_hit = 1'b1;
        state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      mode       <= '0;
      tcnt       <= '0;
      waddr      <= '0;
      raddr      <= '0;
      wdata      <= '0;
      first_addr <= '0;
      errs       <= '0;
      tmo        <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (start) begin
        mode       <= imode;
        errs       <= '0;
        first_addr <= '0;
        tmo        <= 1'b0;
      end
      if (tmo_hit) tmo <= 1'b1;
      if (state_n == S_WR_ISSUE) begin
        waddr <= address(idx_n);
        wdata <= pattern(idx_n);
      end
      if (state_n == S_RD_ISSUE) raddr <= address(idx_n);
      // tcnt = cycles elapsed since the request cycle
      if (state == S_WR_ISSUE || state == S_RD_ISSUE)
        tcnt <= TW'(1);
      else if (state == S_WR_WAIT || state == S_RD_WAIT)
        tcnt <= tcnt + TW'(1);
      if (state == S_RD_WAIT && iread_ack && mism) begin
        if (errs == '0) first_addr <= raddr;
        if (errs != 16'hFFFF) errs <= errs + 16'd1;
      end
    end
  end

  assign owrite_req      = (state == S_WR_ISSUE);
  assign oread_req       = (state == S_RD_ISSUE);
  assign owrite_address  = waddr;
  assign owrite_data     = wdata;
  assign oread_address   = raddr;
  assign obusy           = !(state == S_IDLE || state == S_DONE);
  assign odone           = (state == S_DONE);
  assign opass           = odone && (errs == '0) && !tmo;
  assign oerr_count      = errs;
  assign ofirst_err_addr = first_addr;
  assign otimeout        = tmo;

endmodule
